// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Captures operands, destination, immediate and control word for EX. Operands are
// resolved by forwarding from EX, MEM and WB at capture. The stage detects load-use
// hazards, inserts a bubble, honours flush and downstream hold, and keeps a
// saturating stall counter.
module id_ex_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_src1,
    input  logic [ADDR_W-1:0] in_src2,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_reg_write,
    input  logic              in_is_load,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    input  logic              ex_hold,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_dst,
    output logic              out_reg_write,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [15:0]       stall_count
);

    logic              valid_q,     valid_d;
    logic [ADDR_W-1:0] dst_q,       dst_d;
    logic              reg_write_q, reg_write_d;
    logic              is_load_q,   is_load_d;
    logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [DATA_W-1:0] op1_q,       op1_d;
    logic [DATA_W-1:0] op2_q,       op2_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic              hz;
    logic              stall_raw;
    logic              ex_fwd_en;
    logic [DATA_W-1:0] fwd1;
    logic [DATA_W-1:0] fwd2;

    // Operand resolution: youngest producer first (EX, then MEM, then WB, then register file).
    function automatic logic [DATA_W-1:0] resolve(
        input logic              use_i,
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_en,
        input logic [ADDR_W-1:0] ex_dst,
        input logic [DATA_W-1:0] ex_val,
        input logic              m_en,
        input logic [ADDR_W-1:0] m_dst,
        input logic [DATA_W-1:0] m_val,
        input logic              w_en,
        input logic [ADDR_W-1:0] w_dst,
        input logic [DATA_W-1:0] w_val
    );
        logic [DATA_W-1:0] r;
        r = rf_data;
        if (use_i) begin
            if (ex_en && ex_dst == src) begin
                r = ex_val;
            end else if (m_en && m_dst == src) begin
                r = m_val;
            end else if (w_en && w_dst == src) begin
                // register file writes on the same edge, so its read data is stale
                r = w_val;
            end
        end
        return r;
    endfunction

    // Load-use hazard detection and upstream stall request.
    always_comb begin
        hz = in_valid && valid_q && is_load_q && reg_write_q &&
             ((in_use1 && in_src1 == dst_q) || (in_use2 && in_src2 == dst_q));
        stall_raw = hz || ex_hold;
        stall     = !reset && stall_raw;
    end

    // Forwarded operand values for the instruction being captured.
    always_comb begin
        // a load in EX never forwards; the hazard bubble covers that case
        ex_fwd_en = valid_q && reg_write_q && !is_load_q;
        fwd1 = resolve(in_use1, in_src1, in_data1, ex_fwd_en, dst_q, ex_result,
                       mem_reg_write, mem_dst, mem_data, wb_reg_write, wb_dst, wb_data);
        fwd2 = resolve(in_use2, in_src2, in_data2, ex_fwd_en, dst_q, ex_result,
                       mem_reg_write, mem_dst, mem_data, wb_reg_write, wb_dst, wb_data);
    end

    // Next-state selection: reset, flush, hold, hazard bubble, capture.
    always_comb begin
        valid_d     = valid_q;
        dst_d       = dst_q;
        reg_write_d = reg_write_q;
        is_load_d   = is_load_q;
        ctrl_d      = ctrl_q;
        imm_d       = imm_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        stall_cnt_d = stall_cnt_q;

        if (reset) begin
            valid_d     = 1'b0;
            dst_d       = '0;
            reg_write_d = 1'b0;
            is_load_d   = 1'b0;
            ctrl_d      = '0;
            imm_d       = '0;
            op1_d       = '0;
            op2_d       = '0;
            stall_cnt_d = '0;
        end else begin
            if (stall_raw && stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end

            if (flush || (!ex_hold && hz)) begin
                valid_d     = 1'b0;
                dst_d       = '0;
                reg_write_d = 1'b0;
                is_load_d   = 1'b0;
                ctrl_d      = '0;
                imm_d       = '0;
                op1_d       = '0;
                op2_d       = '0;
            end else if (!ex_hold) begin
                valid_d     = in_valid;
                dst_d       = in_dst;
                reg_write_d = in_valid && in_reg_write;
                is_load_d   = in_valid && in_is_load;
                ctrl_d      = in_valid ? in_ctrl : '0;
                imm_d       = in_imm;
                op1_d       = fwd1;
                op2_d       = fwd2;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        valid_q     <= valid_d;
        dst_q       <= dst_d;
        reg_write_q <= reg_write_d;
        is_load_q   <= is_load_d;
        ctrl_q      <= ctrl_d;
        imm_q       <= imm_d;
        op1_q       <= op1_d;
        op2_q       <= op2_d;
        stall_cnt_q <= stall_cnt_d;
    end

    // Registered outputs.
    always_comb begin
        out_valid     = valid_q;
        out_dst       = dst_q;
        out_reg_write = reg_write_q;
        out_is_load   = is_load_q;
        out_ctrl      = ctrl_q;
        out_imm       = imm_q;
        out_op1       = op1_q;
        out_op2       = op2_q;
        stall_count   = stall_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, directed corner sequences and randomized traffic
// against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_src1, in_src2;
    logic        in_use1, in_use2;
    logic [15:0] in_data1, in_data2;
    logic [2:0]  in_dst;
    logic        in_reg_write, in_is_load;
    logic [15:0] in_imm;
    logic [7:0]  in_ctrl;
    logic        flush, ex_hold;
    logic [15:0] ex_result;
    logic        mem_reg_write;
    logic [2:0]  mem_dst;
    logic [15:0] mem_data;
    logic        wb_reg_write;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;
    logic        stall;
    logic        out_valid;
    logic [2:0]  out_dst;
    logic        out_reg_write, out_is_load;
    logic [7:0]  out_ctrl;
    logic [15:0] out_imm, out_op1, out_op2;
    logic [15:0] stall_count;

    id_ex_stage #(.DATA_W(16), .ADDR_W(3), .CTRL_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_src1(in_src1), .in_src2(in_src2),
        .in_use1(in_use1), .in_use2(in_use2), .in_data1(in_data1), .in_data2(in_data2),
        .in_dst(in_dst), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
        .in_imm(in_imm), .in_ctrl(in_ctrl), .flush(flush), .ex_hold(ex_hold),
        .ex_result(ex_result), .mem_reg_write(mem_reg_write), .mem_dst(mem_dst),
        .mem_data(mem_data), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .stall(stall), .out_valid(out_valid), .out_dst(out_dst),
        .out_reg_write(out_reg_write), .out_is_load(out_is_load), .out_ctrl(out_ctrl),
        .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model of the register contents
    bit          m_valid, m_rw, m_ld;
    logic [2:0]  m_dst;
    logic [7:0]  m_ctrl;
    logic [15:0] m_imm, m_op1, m_op2;
    int          m_cnt;
    bit          s_stall_exp;
    logic        s_stall_act;

    typedef struct packed {
        logic        valid;
        logic [2:0]  src1, src2;
        logic        use1, use2;
        logic [15:0] d1, d2;
        logic [2:0]  dst;
        logic        rw, ld;
        logic [15:0] imm;
        logic [7:0]  ctrl;
        logic [15:0] exr;
        logic        mrw;
        logic [2:0]  mdst;
        logic [15:0] mdata;
        logic        wrw;
        logic [2:0]  wdst;
        logic [15:0] wdata;
        logic        e_stall, e_valid;
        logic [15:0] e_op1, e_op2, e_imm;
        logic [2:0]  e_dst;
        logic        e_rw, e_ld;
        logic [7:0]  e_ctrl;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    function automatic bit model_hz();
        return in_valid && m_valid && m_ld && m_rw &&
               ((in_use1 && in_src1 == m_dst) || (in_use2 && in_src2 == m_dst));
    endfunction

    function automatic logic [15:0] model_fwd(input bit u, input logic [2:0] s, input logic [15:0] rf);
        if (!u) return rf;
        if (m_valid && m_rw && !m_ld && m_dst == s) return ex_result;
        if (mem_reg_write && mem_dst == s) return mem_data;
        if (wb_reg_write && wb_dst == s) return wb_data;
        return rf;
    endfunction

    task automatic model_bubble();
        m_valid = 0; m_rw = 0; m_ld = 0; m_dst = '0; m_ctrl = '0;
        m_imm = '0; m_op1 = '0; m_op2 = '0;
    endtask

    task automatic model_update();
        bit hz;
        logic [15:0] f1, f2;
        hz = model_hz();
        f1 = model_fwd(in_use1, in_src1, in_data1);
        f2 = model_fwd(in_use2, in_src2, in_data2);
        if (reset) begin
            model_bubble();
            m_cnt = 0;
        end else begin
            if (hz || ex_hold) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            if (flush) model_bubble();
            else if (ex_hold) begin end
            else if (hz) model_bubble();
            else begin
                m_valid = in_valid;
                m_rw    = in_valid && in_reg_write;
                m_ld    = in_valid && in_is_load;
                m_ctrl  = in_valid ? in_ctrl : 8'h00;
                m_dst   = in_dst;
                m_imm   = in_imm;
                m_op1   = f1;
                m_op2   = f2;
            end
        end
    endtask

    // one clock: sample stall mid-cycle, then advance model and DUT together
    task automatic tick();
        #4;
        s_stall_exp = !reset && (model_hz() || ex_hold);
        s_stall_act = stall;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".stall"},     {31'd0, s_stall_act}, {31'd0, s_stall_exp});
        chk({tag, ".valid"},     {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".dst"},       {29'd0, out_dst}, {29'd0, m_dst});
        chk({tag, ".rw_ld"},     {30'd0, out_reg_write, out_is_load}, {30'd0, m_rw, m_ld});
        chk({tag, ".ctrl"},      {24'd0, out_ctrl}, {24'd0, m_ctrl});
        chk({tag, ".imm"},       {16'd0, out_imm}, {16'd0, m_imm});
        chk({tag, ".op1"},       {16'd0, out_op1}, {16'd0, m_op1});
        chk({tag, ".op2"},       {16'd0, out_op2}, {16'd0, m_op2});
        chk({tag, ".count"},     {16'd0, stall_count}, m_cnt);
    endtask

    task automatic drive_idle();
        in_valid = 0; in_src1 = '0; in_src2 = '0; in_use1 = 0; in_use2 = 0;
        in_data1 = '0; in_data2 = '0; in_dst = '0; in_reg_write = 0; in_is_load = 0;
        in_imm = '0; in_ctrl = '0; flush = 0; ex_hold = 0; ex_result = '0;
        mem_reg_write = 0; mem_dst = '0; mem_data = '0;
        wb_reg_write = 0; wb_dst = '0; wb_data = '0;
    endtask

    task automatic drive_random();
        in_valid     = ($urandom_range(0, 4) != 0);
        in_src1      = 3'($urandom_range(0, 7));
        in_src2      = 3'($urandom_range(0, 7));
        in_use1      = 1'($urandom);
        in_use2      = 1'($urandom);
        in_data1     = 16'($urandom);
        in_data2     = 16'($urandom);
        in_dst       = 3'($urandom_range(0, 7));
        in_reg_write = ($urandom_range(0, 3) != 0);
        in_is_load   = ($urandom_range(0, 2) == 0);
        in_imm       = 16'($urandom);
        in_ctrl      = 8'($urandom);
        flush        = ($urandom_range(0, 15) == 0);
        ex_hold      = ($urandom_range(0, 7) == 0);
        ex_result    = 16'($urandom);
        mem_reg_write = 1'($urandom);
        mem_dst      = 3'($urandom_range(0, 7));
        mem_data     = 16'($urandom);
        wb_reg_write = 1'($urandom);
        wb_dst       = 3'($urandom_range(0, 7));
        wb_data      = 16'($urandom);
        reset        = ($urandom_range(0, 99) == 0);
    endtask

    task automatic load_instr(input logic [2:0] dst);
        drive_idle();
        in_valid = 1; in_dst = dst; in_reg_write = 1; in_is_load = 1;
        in_imm = 16'h0040; in_ctrl = 8'h81;
    endtask

    initial begin
        //  valid src1 src2 use1 use2 d1 d2 dst rw ld imm ctrl exr | mem | wb | e_stall e_valid e_op1 e_op2 e_imm e_dst e_rw e_ld e_ctrl
        vecs[0] = '{1'b1, 3'd2, 3'd3, 1'b1, 1'b1, 16'h0002, 16'h0003, 3'd4, 1'b1, 1'b0, 16'h00FF, 8'h11, 16'h0000,
                    1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                    1'b0, 1'b1, 16'h0002, 16'h0003, 16'h00FF, 3'd4, 1'b1, 1'b0, 8'h11};
        vecs[1] = '{1'b1, 3'd4, 3'd1, 1'b1, 1'b0, 16'h1111, 16'h2222, 3'd6, 1'b1, 1'b0, 16'h0010, 8'h22, 16'hAAAA,
                    1'b1, 3'd4, 16'hBBBB, 1'b1, 3'd4, 16'hCCCC,
                    1'b0, 1'b1, 16'hAAAA, 16'h2222, 16'h0010, 3'd6, 1'b1, 1'b0, 8'h22};
        vecs[2] = '{1'b1, 3'd4, 3'd1, 1'b1, 1'b0, 16'h1111, 16'h2222, 3'd6, 1'b1, 1'b0, 16'h0020, 8'h33, 16'hAAAA,
                    1'b1, 3'd4, 16'hBBBB, 1'b1, 3'd4, 16'hCCCC,
                    1'b0, 1'b1, 16'hBBBB, 16'h2222, 16'h0020, 3'd6, 1'b1, 1'b0, 8'h33};
        vecs[3] = '{1'b1, 3'd4, 3'd6, 1'b1, 1'b1, 16'h1111, 16'h2222, 3'd3, 1'b1, 1'b0, 16'h0030, 8'h44, 16'hAAAA,
                    1'b0, 3'd4, 16'hBBBB, 1'b1, 3'd4, 16'hCCCC,
                    1'b0, 1'b1, 16'hCCCC, 16'hAAAA, 16'h0030, 3'd3, 1'b1, 1'b0, 8'h44};
        vecs[4] = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h5555, 16'h6666, 3'd5, 1'b1, 1'b1, 16'h0040, 8'hFF, 16'h0000,
                    1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                    1'b0, 1'b0, 16'h5555, 16'h6666, 16'h0040, 3'd5, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd5, 1'b1, 1'b1, 16'h0004, 8'h55, 16'h0000,
                    1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                    1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0004, 3'd5, 1'b1, 1'b1, 8'h55};
        vecs[6] = '{1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 16'h0101, 16'h9999, 3'd7, 1'b1, 1'b0, 16'h0008, 8'h66, 16'h0000,
                    1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000,
                    1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 3'd0, 3'd5, 1'b0, 1'b1, 16'h0101, 16'h9999, 3'd7, 1'b1, 1'b0, 16'h0008, 8'h66, 16'h0000,
                    1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 16'h0000,
                    1'b0, 1'b1, 16'h0101, 16'h1234, 16'h0008, 3'd7, 1'b1, 1'b0, 8'h66};

        model_bubble();
        m_cnt = 0;

        // reset with arbitrary inputs, including ex_hold
        drive_random();
        reset = 1; ex_hold = 1; in_valid = 1;
        tick();
        tick();
        chk("reset.stall", {31'd0, s_stall_act}, 32'd0);
        chk("reset.valid", {31'd0, out_valid}, 32'd0);
        chk("reset.ops", {out_op1, out_op2}, 32'd0);
        chk("reset.misc", {out_dst, out_reg_write, out_is_load, out_ctrl, out_imm}, 32'd0);
        chk("reset.count", {16'd0, stall_count}, 32'd0);

        // vector table from a clean state
        reset = 0;
        for (int i = 0; i < 8; i++) begin
            drive_idle();
            in_valid = vecs[i].valid; in_src1 = vecs[i].src1; in_src2 = vecs[i].src2;
            in_use1 = vecs[i].use1; in_use2 = vecs[i].use2;
            in_data1 = vecs[i].d1; in_data2 = vecs[i].d2; in_dst = vecs[i].dst;
            in_reg_write = vecs[i].rw; in_is_load = vecs[i].ld;
            in_imm = vecs[i].imm; in_ctrl = vecs[i].ctrl; ex_result = vecs[i].exr;
            mem_reg_write = vecs[i].mrw; mem_dst = vecs[i].mdst; mem_data = vecs[i].mdata;
            wb_reg_write = vecs[i].wrw; wb_dst = vecs[i].wdst; wb_data = vecs[i].wdata;
            tick();
            chk($sformatf("vec%0d.stall", i), {31'd0, s_stall_act}, {31'd0, vecs[i].e_stall});
            chk($sformatf("vec%0d.valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d.op1", i), {16'd0, out_op1}, {16'd0, vecs[i].e_op1});
            chk($sformatf("vec%0d.op2", i), {16'd0, out_op2}, {16'd0, vecs[i].e_op2});
            chk($sformatf("vec%0d.imm", i), {16'd0, out_imm}, {16'd0, vecs[i].e_imm});
            chk($sformatf("vec%0d.dst", i), {29'd0, out_dst}, {29'd0, vecs[i].e_dst});
            chk($sformatf("vec%0d.rw_ld", i), {30'd0, out_reg_write, out_is_load},
                {30'd0, vecs[i].e_rw, vecs[i].e_ld});
            chk($sformatf("vec%0d.ctrl", i), {24'd0, out_ctrl}, {24'd0, vecs[i].e_ctrl});
        end
        chk("loaduse.count", {16'd0, stall_count}, 32'd1);

        // hold for three cycles with changing inputs: outputs frozen, counter +3
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            reset = 0; flush = 0; ex_hold = 1;
            tick();
            chk($sformatf("hold%0d.stall", i), {31'd0, s_stall_act}, 32'd1);
            chk($sformatf("hold%0d.op", i), {out_op1, out_op2}, {16'h0101, 16'h1234});
            chk($sformatf("hold%0d.valid_dst", i), {28'd0, out_valid, out_dst}, {28'd0, 1'b1, 3'd7});
        end
        chk("hold.count", {16'd0, stall_count}, 32'd4);

        // flush together with a load-use hazard
        load_instr(3'd2);
        tick();
        drive_idle();
        in_valid = 1; in_src1 = 3'd2; in_use1 = 1; in_dst = 3'd1; in_reg_write = 1; flush = 1;
        tick();
        chk("flushhz.stall", {31'd0, s_stall_act}, 32'd1);
        chk("flushhz.valid", {31'd0, out_valid}, 32'd0);
        chk("flushhz.ctrl", {24'd0, out_ctrl}, 32'd0);

        // hold together with hazard: load stays in EX, then one bubble after hold drops
        load_instr(3'd3);
        tick();
        drive_idle();
        in_valid = 1; in_src2 = 3'd3; in_use2 = 1; in_dst = 3'd1; in_reg_write = 1; ex_hold = 1;
        tick();
        chk("holdhz.stall", {31'd0, s_stall_act}, 32'd1);
        chk("holdhz.load_kept", {28'd0, out_valid, out_is_load, out_dst[1:0]}, {28'd0, 2'b11, 2'd3});
        ex_hold = 0;
        tick();
        chk("holdhz.bubble", {31'd0, out_valid}, 32'd0);
        mem_reg_write = 1; mem_dst = 3'd3; mem_data = 16'h5A5A;
        tick();
        chk("holdhz.fwd", {16'd0, out_op2}, 32'h5A5A);
        chk("holdhz.nostall", {31'd0, s_stall_act}, 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        // saturation under sustained hold
        drive_idle();
        reset = 0;
        ex_hold = 1;
        for (int i = 0; i < 70000; i++) tick();
        chk("sat.count", {16'd0, stall_count}, 32'h0000FFFF);
        tick();
        chk("sat.stays", {16'd0, stall_count}, 32'h0000FFFF);
        reset = 1;
        tick();
        chk("sat.reset", {16'd0, stall_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
